// File: rtl/mem_miss_arbiter_pkg.sv
// Shared types and block-geometry constants for the memory miss arbiter.
// The state encoding is used by the top and by the bench.
package mem_miss_arbiter_pkg;

  localparam int WORDS_PER_BLK = 8;
  localparam int BLK_OFFSET_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    FILL_I,
    FILL_D,
    DONE_I,
    DONE_D,
    WRITE
  } state_t;

endpackage

// File: rtl/mem_miss_arbiter_if.sv
// Cache-side request/fill signals and the memory port, grouped into one bundle.
// The master modport is the arbiter; the slave modport is the caches plus memory.
interface mem_miss_arbiter_if #(
  parameter int ADDR_W = 16
);

  logic              i_miss;
  logic [ADDR_W-1:0] i_miss_addr;
  logic              d_miss;
  logic [ADDR_W-1:0] d_miss_addr;
  logic              d_wr_req;
  logic [ADDR_W-1:0] d_wr_addr;
  logic [15:0]       d_wr_data;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data_in;
  logic [15:0]       mem_data_out;
  logic              mem_data_valid;

  logic              fill_we_i;
  logic              fill_we_d;
  logic [2:0]        fill_word;
  logic [15:0]       fill_data;
  logic              fill_done_i;
  logic              fill_done_d;
  logic              d_wr_done;
  logic              busy;

  modport master (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr,
    input  d_wr_req, d_wr_addr, d_wr_data,
    input  mem_data_out, mem_data_valid,
    output mem_en, mem_wr, mem_addr, mem_data_in,
    output fill_we_i, fill_we_d, fill_word, fill_data,
    output fill_done_i, fill_done_d, d_wr_done, busy
  );

  modport slave (
    output i_miss, i_miss_addr, d_miss, d_miss_addr,
    output d_wr_req, d_wr_addr, d_wr_data,
    output mem_data_out, mem_data_valid,
    input  mem_en, mem_wr, mem_addr, mem_data_in,
    input  fill_we_i, fill_we_d, fill_word, fill_data,
    input  fill_done_i, fill_done_d, d_wr_done, busy
  );

endinterface

// File: rtl/mem_miss_arbiter_word_counter.sv
// Small up-counter with synchronous clear (clear wins) and async reset.
// Used for both the read-issue count and the returned-beat count.
module word_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/mem_miss_arbiter.sv
// Arbitrates I-miss fills, D-miss fills and D write-through stores onto the
// single multicycle memory port, streaming returned fill words into the caches.
module mem_miss_arbiter
  import mem_miss_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 4
) (
  input logic                clk,
  input logic                rst,
  mem_miss_arbiter_if.master bus
);

  localparam logic [CNT_W-1:0] BLK_FULL = CNT_W'(WORDS_PER_BLK);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(WORDS_PER_BLK - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  rcv_cnt;

  logic filling;
  logic issuing;
  logic beat;
  logic last_beat;

  assign filling   = (state == FILL_I) || (state == FILL_D);
  assign issuing   = filling && (issue_cnt < BLK_FULL);
  assign beat      = filling && bus.mem_data_valid && (rcv_cnt != BLK_FULL);
  assign last_beat = beat && (rcv_cnt == BLK_LAST);

  word_counter #(.CNT_W(CNT_W)) u_issue_cnt (
    .clk (clk),
    .rst (rst),
    .clr (last_beat),
    .inc (issuing),
    .cnt (issue_cnt)
  );

  word_counter #(.CNT_W(CNT_W)) u_rcv_cnt (
    .clk (clk),
    .rst (rst),
    .clr (last_beat),
    .inc (beat),
    .cnt (rcv_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Request latches follow the same priority as the IDLE decision below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_addr <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else if (state == IDLE) begin
      if (bus.d_miss)
        base_addr <= {bus.d_miss_addr[ADDR_W-1:BLK_OFFSET_W], {BLK_OFFSET_W{1'b0}}};
      else if (bus.d_wr_req) begin
        wr_addr <= bus.d_wr_addr;
        wr_data <= bus.d_wr_data;
      end else if (bus.i_miss)
        base_addr <= {bus.i_miss_addr[ADDR_W-1:BLK_OFFSET_W], {BLK_OFFSET_W{1'b0}}};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.d_miss)
          state_nxt = FILL_D;
        else if (bus.d_wr_req)
          state_nxt = WRITE;
        else if (bus.i_miss)
          state_nxt = FILL_I;
      end
      FILL_I:  if (last_beat) state_nxt = DONE_I;
      FILL_D:  if (last_beat) state_nxt = DONE_D;
      DONE_I:  state_nxt = IDLE;
      DONE_D:  state_nxt = IDLE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Fill strobes follow the returned beat in the same cycle so the cache
  // captures fill_data, which is the memory read bus passed straight through.
  always_comb begin
    bus.mem_en      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_data_in = '0;
    bus.fill_we_i   = 1'b0;
    bus.fill_we_d   = 1'b0;
    bus.fill_word   = '0;
    bus.fill_done_i = 1'b0;
    bus.fill_done_d = 1'b0;
    bus.d_wr_done   = 1'b0;
    bus.busy        = (state != IDLE);
    case (state)
      FILL_I, FILL_D: begin
        if (issuing) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = {base_addr[ADDR_W-1:BLK_OFFSET_W], issue_cnt[2:0], 1'b0};
        end
        bus.fill_word = rcv_cnt[2:0];
        bus.fill_we_i = beat && (state == FILL_I);
        bus.fill_we_d = beat && (state == FILL_D);
      end
      DONE_I: bus.fill_done_i = 1'b1;
      DONE_D: bus.fill_done_d = 1'b1;
      WRITE: begin
        bus.mem_en      = 1'b1;
        bus.mem_wr      = 1'b1;
        bus.mem_addr    = wr_addr;
        bus.mem_data_in = wr_data;
        bus.d_wr_done   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.fill_data = bus.mem_data_out;

endmodule

// File: tb/tb_mem_miss_arbiter.sv
// Directed scoreboard bench for mem_miss_arbiter with a latency/gap memory model.
// Expected reads, fill writes, stores and done pulses are queued at stimulus time.
module tb_mem_miss_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_miss_arbiter_if #(.ADDR_W(16)) bus ();

  mem_miss_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        kind;
    logic [2:0]  word;
    logic [15:0] data;
  } fill_t;

  typedef struct {
    logic [15:0] addr;
    int          ready;
  } rd_t;

  int vectors     = 0;
  int miscompares = 0;

  fill_t       exp_fill[$];
  logic [15:0] exp_rd[$];
  logic [31:0] exp_wr[$];
  logic [2:0]  exp_done[$];

  int   fill_writes = 0;
  int   mem_writes  = 0;
  int   rd_seen     = 0;
  logic prev_rd     = 1'b0;

  rd_t         mq[$];
  int          lat       = 3;
  bit          irregular = 1'b0;
  int          cyc       = 0;
  int          gap       = 0;
  logic        smp_en, smp_wr;
  logic [15:0] smp_addr;
  fill_t       mon_e;
  logic [15:0] mon_a;
  logic [31:0] mon_w;
  logic [2:0]  mon_d;

  function automatic logic [15:0] mem_func(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic push_fill(input logic kind, input logic [15:0] base);
    for (int w = 0; w < 8; w++) begin
      fill_t e;
      logic [15:0] a;
      a = base + 16'(2 * w);
      exp_rd.push_back(a);
      e.kind = kind;
      e.word = 3'(w);
      e.data = mem_func(a);
      exp_fill.push_back(e);
    end
    exp_done.push_back(kind ? 3'b010 : 3'b100);
  endtask

  task automatic apply_stimulus(input logic im, input logic [15:0] ia,
                                input logic dm, input logic [15:0] da,
                                input logic wr, input logic [15:0] wa,
                                input logic [15:0] wd);
    bus.i_miss      = im;
    bus.i_miss_addr = ia;
    bus.d_miss      = dm;
    bus.d_miss_addr = da;
    bus.d_wr_req    = wr;
    bus.d_wr_addr   = wa;
    bus.d_wr_data   = wd;
  endtask

  task automatic wait_done(input string tag, input logic [2:0] which);
    int n = 0;
    while (n < 400 && {bus.fill_done_i, bus.fill_done_d, bus.d_wr_done} !== which) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_done"}, 64'(n < 400), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_mem"}, 64'({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_data_in}), 64'd0);
    check_output({tag, "_fill"}, 64'({bus.fill_we_i, bus.fill_we_d, bus.fill_word, bus.fill_data,
                                      bus.fill_done_i, bus.fill_done_d, bus.d_wr_done, bus.busy}), 64'd0);
  endtask

  // Memory model: samples the port at each edge, returns reads in order after
  // the programmed latency, optionally with random idle gaps between beats.
  always begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mq.delete();
      gap                = 0;
      bus.mem_data_valid = 1'b0;
      bus.mem_data_out   = 16'h0000;
    end else begin
      smp_en   = bus.mem_en;
      smp_wr   = bus.mem_wr;
      smp_addr = bus.mem_addr;
      cyc++;
      #1;
      if (mq.size() > 0 && mq[0].ready <= cyc && gap == 0) begin
        bus.mem_data_valid = 1'b1;
        bus.mem_data_out   = mem_func(mq[0].addr);
        void'(mq.pop_front());
        gap = irregular ? int'($urandom_range(0, 3)) : 0;
      end else begin
        bus.mem_data_valid = 1'b0;
        bus.mem_data_out   = 16'h0000;
        if (gap > 0) gap--;
      end
      if (smp_en && !smp_wr) mq.push_back('{smp_addr, cyc + lat});
      if (smp_en && smp_wr) mem_writes++;
    end
  end

  // Output monitor, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.fill_we_i || bus.fill_we_d) begin
        fill_writes++;
        check_output("fill_overlap", 64'(bus.fill_we_i & bus.fill_we_d), 64'd0);
        if (exp_fill.size() == 0)
          check_output("fill_unexpected", 64'd1, 64'd0);
        else begin
          mon_e = exp_fill.pop_front();
          check_output("fill_kind", 64'(bus.fill_we_d), 64'(mon_e.kind));
          check_output("fill_word", 64'(bus.fill_word), 64'(mon_e.word));
          check_output("fill_data", 64'(bus.fill_data), 64'(mon_e.data));
        end
      end
      if (bus.mem_en && !bus.mem_wr) begin
        if (rd_seen % 8 != 0) check_output("rd_consecutive", 64'(prev_rd), 64'd1);
        rd_seen++;
        if (exp_rd.size() == 0)
          check_output("rd_unexpected", 64'd1, 64'd0);
        else begin
          mon_a = exp_rd.pop_front();
          check_output("rd_addr", 64'(bus.mem_addr), 64'(mon_a));
        end
      end
      if (bus.mem_en && bus.mem_wr) begin
        if (exp_wr.size() == 0)
          check_output("wr_unexpected", 64'd1, 64'd0);
        else begin
          mon_w = exp_wr.pop_front();
          check_output("wr_addr_data", 64'({bus.mem_addr, bus.mem_data_in}), 64'(mon_w));
        end
      end
      if (bus.fill_done_i || bus.fill_done_d || bus.d_wr_done) begin
        if (exp_done.size() == 0)
          check_output("done_unexpected", 64'd1, 64'd0);
        else begin
          mon_d = exp_done.pop_front();
          check_output("done_pulse", 64'({bus.fill_done_i, bus.fill_done_d, bus.d_wr_done}), 64'(mon_d));
        end
      end
      prev_rd = bus.mem_en && !bus.mem_wr;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fw0;
    int wb0;
    rst = 1'b1;
    apply_stimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    #2;
    check_all_zero("reset_state");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Plain I fill from a mid-block address.
    fw0 = fill_writes;
    push_fill(1'b0, 16'h1230);
    apply_stimulus(1'b1, 16'h1236, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    wait_done("t1_i", 3'b100);
    bus.i_miss = 1'b0;
    check_output("t1_fill_count", 64'(fill_writes - fw0), 64'd8);
    @(negedge clk);
    check_output("t1_busy_clear", 64'(bus.busy), 64'd0);

    // Simultaneous D and I misses: D first.
    fw0 = fill_writes;
    push_fill(1'b1, 16'h2040);
    push_fill(1'b0, 16'h0100);
    apply_stimulus(1'b1, 16'h0100, 1'b1, 16'h2040, 1'b0, 16'h0, 16'h0);
    wait_done("t2_d", 3'b010);
    bus.d_miss = 1'b0;
    check_output("t2_d_fill_count", 64'(fill_writes - fw0), 64'd8);
    @(negedge clk);
    check_output("t2_idle_gap", 64'(bus.busy), 64'd0);
    wait_done("t2_i", 3'b100);
    bus.i_miss = 1'b0;
    @(negedge clk);
    check_output("t2_busy_clear", 64'(bus.busy), 64'd0);

    // Store beats a pending I miss.
    exp_wr.push_back({16'h3002, 16'hBEEF});
    exp_done.push_back(3'b001);
    push_fill(1'b0, 16'h0450);
    apply_stimulus(1'b1, 16'h0456, 1'b0, 16'h0, 1'b1, 16'h3002, 16'hBEEF);
    wait_done("t3_w", 3'b001);
    bus.d_wr_req = 1'b0;
    @(negedge clk);
    check_output("t3_idle_after_wr", 64'(bus.busy), 64'd0);
    wait_done("t3_i", 3'b100);
    bus.i_miss = 1'b0;
    @(negedge clk);

    // D fill with irregular beat spacing.
    irregular = 1'b1;
    fw0 = fill_writes;
    push_fill(1'b1, 16'h5A70);
    apply_stimulus(1'b0, 16'h0, 1'b1, 16'h5A7C, 1'b0, 16'h0, 16'h0);
    wait_done("t4_d", 3'b010);
    bus.d_miss = 1'b0;
    check_output("t4_fill_count", 64'(fill_writes - fw0), 64'd8);
    irregular = 1'b0;
    @(negedge clk);

    // Asynchronous reset after three beats of a D fill, then a clean refill.
    fw0 = fill_writes;
    push_fill(1'b1, 16'h6000);
    apply_stimulus(1'b0, 16'h0, 1'b1, 16'h6008, 1'b0, 16'h0, 16'h0);
    for (int n = 0; n < 200 && (fill_writes - fw0) < 3; n++) @(negedge clk);
    check_output("t5_three_beats", 64'(fill_writes - fw0), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("t5_async_reset");
    exp_fill.delete();
    exp_rd.delete();
    exp_done.delete();
    rd_seen = 0;
    prev_rd = 1'b0;
    push_fill(1'b1, 16'h6000);
    @(negedge clk);
    rst = 1'b0;
    fw0 = fill_writes;
    wait_done("t5_refill", 3'b010);
    bus.d_miss = 1'b0;
    check_output("t5_refill_count", 64'(fill_writes - fw0), 64'd8);
    @(negedge clk);

    // Registered store requester: exactly one memory write.
    wb0 = mem_writes;
    exp_wr.push_back({16'h7004, 16'h1234});
    exp_done.push_back(3'b001);
    apply_stimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h7004, 16'h1234);
    wait_done("t6_w", 3'b001);
    bus.d_wr_req = 1'b0;
    repeat (4) @(negedge clk);
    check_output("t6_one_write", 64'(mem_writes - wb0), 64'd1);
    check_output("t6_busy_clear", 64'(bus.busy), 64'd0);

    check_output("scoreboard_drained",
                 64'(exp_fill.size() + exp_rd.size() + exp_wr.size() + exp_done.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
